// File: rtl/cereal_arbiter_pkg.sv
// cereal_arbiter_pkg: shared FSM encoding and default byte width for the cereal arbiter
package cereal_arbiter_pkg;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, NEXT = 2'd2} state_e;
endpackage

// File: rtl/cereal_arbiter_rr_pick.sv
// cereal_arbiter_rr_pick: rotate-priority picker, first request after ptr wins
module cereal_arbiter_rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  pick_o,
  output logic [IW-1:0] pick_idx_o,
  output logic          any_o
);
  logic [IW-1:0] j;
  // walk from farthest to nearest so the slot right after ptr is assigned last
  always_comb begin
    pick_idx_o = '0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(ptr_i) + k) % N);
      if (req_i[j]) pick_idx_o = j;
    end
  end
  assign any_o = |req_i;
  assign pick_o = any_o ? N'(1) << pick_idx_o : '0;
endmodule

// File: rtl/cereal_arbiter.sv
// cereal_arbiter: round-robin word-granular arbiter in front of the cereal serializer
module cereal_arbiter import cereal_arbiter_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_WAIT = 1 << 20,
  localparam int IW = $clog2(N_REQ),
  localparam int CW = $clog2(MAX_WAIT)
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_last_i,
  output logic [N_REQ-1:0]        req_ack_o,
  output logic [N_REQ-1:0]        grant_o,
  output logic [DATA_W-1:0]       tx_data_o,
  output logic                    tx_start_o,
  input  logic                    tx_ready_i,
  output logic                    busy_o,
  output logic                    timeout_err_o
);
  state_e state_q;
  logic [IW-1:0] owner_q, ptr_q, pick_idx;
  logic [CW-1:0] cnt_q;
  logic [N_REQ-1:0] pick;
  logic last_q, ready_q, any, done, cap, wd;
  cereal_arbiter_rr_pick #(.N(N_REQ)) u_pick (
    .req_i(req_i), .ptr_i(ptr_q), .pick_o(pick), .pick_idx_o(pick_idx), .any_o(any)
  );
  assign done = tx_ready_i & ~ready_q;
  // a nonzero req_ack marks the first NEXT cycle, where the requester is still switching bytes
  assign cap = state_q == NEXT && !(|req_ack_o) && req_i[owner_q];
  assign wd = cnt_q == CW'(MAX_WAIT - 1) && (state_q == SEND ? !done : state_q == NEXT && !cap);
  always_ff @(posedge sysclk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q <= IW'(N_REQ - 1);
      last_q <= 1'b0;
      ready_q <= 1'b1;
      cnt_q <= '0;
      grant_o <= '0;
      req_ack_o <= '0;
      tx_data_o <= '0;
      tx_start_o <= 1'b0;
      busy_o <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      ready_q <= tx_ready_i;
      req_ack_o <= '0;
      timeout_err_o <= 1'b0;
      cnt_q <= state_q == IDLE ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: if (any) begin
          state_q <= SEND;
          owner_q <= pick_idx;
          grant_o <= pick;
          tx_data_o <= req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
          last_q <= req_last_i[pick_idx];
          tx_start_o <= 1'b1;
          busy_o <= 1'b1;
        end
        SEND: if (done) begin
          req_ack_o <= grant_o;
          tx_start_o <= 1'b0;
          cnt_q <= '0;
          state_q <= last_q ? IDLE : NEXT;
          if (last_q) begin
            ptr_q <= owner_q;
            grant_o <= '0;
            busy_o <= 1'b0;
          end
        end
        NEXT: if (cap) begin
          state_q <= SEND;
          tx_data_o <= req_data_i[int'(owner_q)*DATA_W +: DATA_W];
          last_q <= req_last_i[owner_q];
          tx_start_o <= 1'b1;
          cnt_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
      if (wd) begin
        state_q <= IDLE;
        tx_start_o <= 1'b0;
        grant_o <= '0;
        busy_o <= 1'b0;
        ptr_q <= owner_q;
        timeout_err_o <= 1'b1;
        cnt_q <= '0;
      end
    end
endmodule
